level_ctrl: RTL and testbench

- Game-progress controller directly downstream of the sequence comparator.
- Consumes the comparator's win/loose flags and tracks current level (1..MAX_LEVEL), remaining lives and score.
- Drives level_num and the levelupdated handshake back to the comparator and RNG stages.
- Flags game over / game complete to the display stage.

---
 rtl/game_pkg.sv | 27 ++
 rtl/level_ctrl_rise_det.sv | 32 +++
 rtl/level_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_level_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Package     : game_pkg
// Description : Shared game types and constants. Holds the progress FSM state
//               encoding, the default level/lives limits and the 4-bit level
//               code type used by the comparator, RNG and level controller.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
package game_pkg;

   // Level code shared with the comparator and RNG stages
   typedef logic [3:0] level_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PLAY   = 3'd1,
      UPDATE = 3'd2,
      OVER   = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam int     MAX_LEVEL_DEF  = 5;
   localparam int     LIVES_INIT_DEF = 3;
   localparam level_t LEVEL_FIRST    = 4'd1;

endpackage : game_pkg
`default_nettype wire

// File: rtl/level_ctrl_rise_det.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : rise_det
// Description : 1-bit rising-edge detector. Registers the input once and
//               flags the cycle where the input is high and was low.
// Ports       : clock - system clock, rising edge
//               rst   - asynchronous active-high reset
//               d     - input level
//               rise  - high while d=1 and the previous sample was 0
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module rise_det (
   input  logic clock,
   input  logic rst,
   input  logic d,
   output logic rise
);

   logic r_d;

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         r_d <= 1'b0;
      end else begin
         r_d <= d;
      end
   end

   assign rise = d & ~r_d;

endmodule : rise_det
`default_nettype wire

// File: rtl/level_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : level_ctrl
// Description : Game-progress controller. Consumes comparator win/loose flags
//               (rising edges only), tracks level, lives and a saturating
//               score, and handshakes level changes back upstream.
// Ports       : clock         - system clock, rising edge
//               rst           - asynchronous active-high reset
//               auth_bit      - user authenticated, starts a session
//               logout        - abort session, return to idle
//               win           - comparator win flag (pulse)
//               loose         - comparator lose flag (may be held)
//               level_num     - current level, 1..MAX_LEVEL
//               levelupdated  - one-cycle pulse after level_num advanced
//               lives         - remaining lives
//               score         - accumulated, saturating score
//               game_over     - lives exhausted (held)
//               game_complete - last level won (held)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module level_ctrl
   import game_pkg::*;
#(
   parameter int MAX_LEVEL  = MAX_LEVEL_DEF,
   parameter int LIVES_INIT = LIVES_INIT_DEF,
   parameter int LIVES_W    = 2,
   parameter int SCORE_W    = 8
) (
   input  logic               clock,
   input  logic               rst,
   input  logic               auth_bit,
   input  logic               logout,
   input  logic               win,
   input  logic               loose,
   output level_t             level_num,
   output logic               levelupdated,
   output logic [LIVES_W-1:0] lives,
   output logic [SCORE_W-1:0] score,
   output logic               game_over,
   output logic               game_complete
);

   localparam level_t             LVL_MAX  = level_t'(MAX_LEVEL);
   localparam logic [LIVES_W-1:0] LIVES_LD = LIVES_W'(LIVES_INIT);
   localparam logic [LIVES_W-1:0] LIVES_1  = LIVES_W'(1);
   localparam int                 SUM_W    = SCORE_W + 1;

   // Registered state and outputs
   state_t             r_state;
   level_t             r_level;
   logic               r_lvlupd;
   logic [LIVES_W-1:0] r_lives;
   logic [SCORE_W-1:0] r_score;
   logic               r_over;
   logic               r_done;

   // Next-state values
   state_t             w_state_nxt;
   level_t             w_level_nxt;
   logic               w_lvlupd_nxt;
   logic [LIVES_W-1:0] w_lives_nxt;
   logic [SCORE_W-1:0] w_score_nxt;
   logic               w_over_nxt;
   logic               w_done_nxt;

   logic               w_win_r;
   logic               w_loose_r;
   logic [SUM_W-1:0]   w_sum;
   logic [SCORE_W-1:0] w_score_sat;

   rise_det u_win_det (
      .clock (clock),
      .rst   (rst),
      .d     (win),
      .rise  (w_win_r)
   );

   rise_det u_loose_det (
      .clock (clock),
      .rst   (rst),
      .d     (loose),
      .rise  (w_loose_r)
   );

   // One extra bit catches the carry; a carry means the score clamps to all-ones
   assign w_sum       = {1'b0, r_score} + SUM_W'(r_level);
   assign w_score_sat = w_sum[SCORE_W] ? {SCORE_W{1'b1}} : w_sum[SCORE_W-1:0];

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_level  <= LEVEL_FIRST;
         r_lvlupd <= 1'b0;
         r_lives  <= LIVES_LD;
         r_score  <= '0;
         r_over   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_level  <= w_level_nxt;
         r_lvlupd <= w_lvlupd_nxt;
         r_lives  <= w_lives_nxt;
         r_score  <= w_score_nxt;
         r_over   <= w_over_nxt;
         r_done   <= w_done_nxt;
      end
   end

   always_comb begin
      // Hold everything by default; levelupdated is a strobe and defaults low
      w_state_nxt  = r_state;
      w_level_nxt  = r_level;
      w_lvlupd_nxt = 1'b0;
      w_lives_nxt  = r_lives;
      w_score_nxt  = r_score;
      w_over_nxt   = r_over;
      w_done_nxt   = r_done;

      unique case (r_state)
         IDLE: begin
            w_level_nxt = LEVEL_FIRST;
            w_lives_nxt = LIVES_LD;
            w_score_nxt = '0;
            w_over_nxt  = 1'b0;
            w_done_nxt  = 1'b0;
            if (auth_bit) begin
               w_state_nxt = PLAY;
            end
         end

         PLAY: begin
            if (logout) begin
               w_state_nxt = IDLE;
            end else if (w_loose_r) begin
               // A loss takes precedence over a simultaneous win
               if (r_lives > LIVES_1) begin
                  w_lives_nxt = r_lives - LIVES_1;
               end else begin
                  w_lives_nxt = '0;
                  w_over_nxt  = 1'b1;
                  w_state_nxt = OVER;
               end
            end else if (w_win_r) begin
               w_score_nxt = w_score_sat;
               if (r_level < LVL_MAX) begin
                  w_level_nxt = r_level + 4'd1;
                  w_state_nxt = UPDATE;
               end else begin
                  w_done_nxt  = 1'b1;
                  w_state_nxt = DONE;
               end
            end
         end

         UPDATE: begin
            // The pulse lands one cycle after level_num so upstream stages
            // see the new level by the time they react to levelupdated
            if (logout) begin
               w_state_nxt = IDLE;
            end else begin
               w_lvlupd_nxt = 1'b1;
               w_state_nxt  = PLAY;
            end
         end

         OVER, DONE: begin
            if (logout) begin
               w_state_nxt = IDLE;
            end
         end

         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign level_num     = r_level;
   assign levelupdated  = r_lvlupd;
   assign lives         = r_lives;
   assign score         = r_score;
   assign game_over     = r_over;
   assign game_complete = r_done;

endmodule : level_ctrl
`default_nettype wire

// File: tb/tb_level_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_level_ctrl
// Description : Scoreboard bench for level_ctrl. Two instances share stimulus:
//               u_dut with default parameters and u_sat with SCORE_W=4,
//               MAX_LEVEL=7 so the score reaches its saturation point.
//               Expected level/score pairs are queued when a win is issued
//               and popped by a monitor on every levelupdated pulse.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_level_ctrl;

   typedef struct {
      int lvl;
      int sc;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       auth_bit;
   logic       logout;
   logic       win;
   logic       loose;

   logic [3:0] d_level;
   logic       d_lu;
   logic [1:0] d_lives;
   logic [7:0] d_score;
   logic       d_over;
   logic       d_done;

   logic [3:0] s_level;
   logic       s_lu;
   logic [1:0] s_lives;
   logic [3:0] s_score;
   logic       s_over;
   logic       s_done;

   int   n_chk   = 0;
   int   n_fail  = 0;
   int   n_pul_d = 0;
   int   n_pul_s = 0;
   exp_t q_dut[$];
   exp_t q_sat[$];

   // Hand-computed expectations for seven consecutive wins from level 1
   int dut_up [7] = '{1, 1, 1, 1, 0, 0, 0};
   int dut_lvl[7] = '{2, 3, 4, 5, 5, 5, 5};
   int dut_sc [7] = '{1, 3, 6, 10, 15, 15, 15};
   int sat_up [7] = '{1, 1, 1, 1, 1, 1, 0};
   int sat_lvl[7] = '{2, 3, 4, 5, 6, 7, 7};
   int sat_sc [7] = '{1, 3, 6, 10, 15, 15, 15};

   level_ctrl u_dut (
      .clock         (clk),
      .rst           (rst),
      .auth_bit      (auth_bit),
      .logout        (logout),
      .win           (win),
      .loose         (loose),
      .level_num     (d_level),
      .levelupdated  (d_lu),
      .lives         (d_lives),
      .score         (d_score),
      .game_over     (d_over),
      .game_complete (d_done)
   );

   level_ctrl #(
      .MAX_LEVEL (7),
      .SCORE_W   (4)
   ) u_sat (
      .clock         (clk),
      .rst           (rst),
      .auth_bit      (auth_bit),
      .logout        (logout),
      .win           (win),
      .loose         (loose),
      .level_num     (s_level),
      .levelupdated  (s_lu),
      .lives         (s_lives),
      .score         (s_score),
      .game_over     (s_over),
      .game_complete (s_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push_exp(input int k);
      exp_t e;
      if (dut_up[k] != 0) begin
         e.lvl = dut_lvl[k];
         e.sc  = dut_sc[k];
         q_dut.push_back(e);
      end
      if (sat_up[k] != 0) begin
         e.lvl = sat_lvl[k];
         e.sc  = sat_sc[k];
         q_sat.push_back(e);
      end
   endtask

   // Monitor: every levelupdated pulse must match the oldest queued expectation
   always @(negedge clk) begin
      exp_t e;
      if (d_lu) begin
         n_pul_d++;
         if (q_dut.size() == 0) begin
            chk("dut unexpected levelupdated", int'(d_lu), 0);
         end else begin
            e = q_dut.pop_front();
            chk("dut level at pulse", int'(d_level), e.lvl);
            chk("dut score at pulse", int'(d_score), e.sc);
         end
      end
      if (s_lu) begin
         n_pul_s++;
         if (q_sat.size() == 0) begin
            chk("sat unexpected levelupdated", int'(s_lu), 0);
         end else begin
            e = q_sat.pop_front();
            chk("sat level at pulse", int'(s_level), e.lvl);
            chk("sat score at pulse", int'(s_score), e.sc);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      rst      = 1'b1;
      auth_bit = 1'b0;
      logout   = 1'b0;
      win      = 1'b0;
      loose    = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset level_num", int'(d_level), 1);
      chk("reset lives", int'(d_lives), 3);
      chk("reset score", int'(d_score), 0);
      chk("reset levelupdated", int'(d_lu), 0);
      chk("reset game_over", int'(d_over), 0);
      chk("reset game_complete", int'(d_done), 0);

      tick();
      rst      = 1'b0;
      auth_bit = 1'b1;
      tick();
      auth_bit = 1'b0;

      // First win: level moves right after the edge, pulse one cycle later
      push_exp(0);
      win = 1'b1;
      tick();
      win = 1'b0;
      @(negedge clk);
      chk("t1 level after win edge", int'(d_level), 2);
      chk("t1 no pulse yet", int'(d_lu), 0);
      chk("t1 score", int'(d_score), 1);
      tick();
      @(negedge clk);
      chk("t1 pulse next cycle", int'(d_lu), 1);
      tick();
      @(negedge clk);
      chk("t1 pulse one cycle only", int'(d_lu), 0);

      // Remaining wins; u_dut completes at level 5, u_sat carries on to 7
      for (int k = 1; k < 7; k++) begin
         tick();
         push_exp(k);
         win = 1'b1;
         tick();
         win = 1'b0;
         tick();
         tick();
         @(negedge clk);
         chk("t2 dut level", int'(d_level), dut_lvl[k]);
         chk("t2 dut score", int'(d_score), dut_sc[k]);
         chk("t2 sat level", int'(s_level), sat_lvl[k]);
         chk("t2 sat score", int'(s_score), sat_sc[k]);
      end
      chk("t2 dut game_complete", int'(d_done), 1);
      chk("t2 dut pulse count", n_pul_d, 4);
      chk("t2 sat game_complete", int'(s_done), 1);
      chk("t2 sat pulse count", n_pul_s, 6);

      // logout from DONE, then IDLE reloads the session values
      tick();
      logout = 1'b1;
      tick();
      logout = 1'b0;
      tick();
      @(negedge clk);
      chk("logout level_num", int'(d_level), 1);
      chk("logout lives", int'(d_lives), 3);
      chk("logout score", int'(d_score), 0);
      chk("logout game_complete", int'(d_done), 0);

      // Held loose counts once per rising edge
      tick();
      auth_bit = 1'b1;
      tick();
      auth_bit = 1'b0;
      loose    = 1'b1;
      tick();
      @(negedge clk);
      chk("t3 lives first edge", int'(d_lives), 2);
      repeat (9) tick();
      @(negedge clk);
      chk("t3 lives while held", int'(d_lives), 2);
      loose = 1'b0;
      tick();
      tick();
      loose = 1'b1;
      tick();
      @(negedge clk);
      chk("t3 lives second edge", int'(d_lives), 1);
      chk("t3 not over yet", int'(d_over), 0);
      loose = 1'b0;
      tick();
      tick();
      loose = 1'b1;
      tick();
      @(negedge clk);
      chk("t3 lives third edge", int'(d_lives), 0);
      chk("t3 game_over", int'(d_over), 1);
      chk("t3 sat game_over", int'(s_over), 1);
      // Edges in OVER are ignored
      loose = 1'b0;
      tick();
      win = 1'b1;
      tick();
      win = 1'b0;
      tick();
      loose = 1'b1;
      tick();
      loose = 1'b0;
      tick();
      @(negedge clk);
      chk("t3 over lives held", int'(d_lives), 0);
      chk("t3 over level held", int'(d_level), 1);
      chk("t3 over score held", int'(d_score), 0);
      chk("t3 over flag held", int'(d_over), 1);
      tick();
      logout = 1'b1;
      tick();
      logout = 1'b0;
      tick();
      @(negedge clk);
      chk("t3 logout lives", int'(d_lives), 3);
      chk("t3 logout game_over", int'(d_over), 0);

      // Win and loose together at level 2: loss wins, no level change
      tick();
      auth_bit = 1'b1;
      tick();
      auth_bit = 1'b0;
      push_exp(0);
      win = 1'b1;
      tick();
      win = 1'b0;
      repeat (3) tick();
      win   = 1'b1;
      loose = 1'b1;
      tick();
      win   = 1'b0;
      loose = 1'b0;
      tick();
      tick();
      @(negedge clk);
      chk("t4 lives", int'(d_lives), 2);
      chk("t4 level", int'(d_level), 2);
      chk("t4 score", int'(d_score), 1);
      chk("t4 no pulse", int'(d_lu), 0);

      // logout while in UPDATE suppresses the pulse
      tick();
      win = 1'b1;
      tick();
      win    = 1'b0;
      logout = 1'b1;
      @(negedge clk);
      chk("t6 level in UPDATE", int'(d_level), 3);
      chk("t6 score in UPDATE", int'(d_score), 3);
      tick();
      logout = 1'b0;
      @(negedge clk);
      chk("t6 no pulse after logout", int'(d_lu), 0);
      tick();
      @(negedge clk);
      chk("t6 idle level", int'(d_level), 1);
      chk("t6 idle lives", int'(d_lives), 3);
      chk("t6 idle score", int'(d_score), 0);

      // Async reset mid-game cancels a pending pulse without a clock edge
      tick();
      auth_bit = 1'b1;
      tick();
      auth_bit = 1'b0;
      push_exp(0);
      win = 1'b1;
      tick();
      win = 1'b0;
      repeat (3) tick();
      win = 1'b1;
      tick();
      win = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      chk("rst async level", int'(d_level), 1);
      chk("rst async score", int'(d_score), 0);
      chk("rst async lives", int'(d_lives), 3);
      chk("rst async sat level", int'(s_level), 1);
      @(negedge clk);
      @(negedge clk);
      chk("rst pulse cancelled", int'(d_lu), 0);
      tick();
      rst = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      chk("dut queue drained", q_dut.size(), 0);
      chk("sat queue drained", q_sat.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule : tb_level_ctrl
`default_nettype wire
